// File: rtl/product_code_decoder_pkg.sv
// rtl/product_code_decoder_pkg.sv - shared types and layout helpers for the product-code decoder
//
// Purpose : status and FSM state encodings plus codeword layout index functions.
// Contents: status_e, state_e, data_idx, rowpar_idx, colpar_idx.
package product_code_pkg;

  typedef enum logic [1:0] {
    CLEAN         = 2'd0,
    SINGLE_DATA   = 2'd1,
    CHECK_BIT     = 2'd2,
    UNCORRECTABLE = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    LOCATE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Bit position of data bit (r,c) inside the codeword.
  function automatic int data_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

  // Bit position of the parity bit for row r.
  function automatic int rowpar_idx(input int r, input int rows, input int cols);
    return rows * cols + r;
  endfunction

  // Bit position of the parity bit for column c.
  function automatic int colpar_idx(input int c, input int rows, input int cols);
    return rows * cols + rows + c;
  endfunction

endpackage

// File: rtl/product_code_decoder_if.sv
// rtl/product_code_decoder_if.sv - codeword in / result out bundle for the product-code decoder
//
// Purpose : groups the input handshake, result handshake and statistics outputs.
// Signals : in_valid/in_ready/in_word/correct_en (word in),
//           out_valid/out_ready/out_data/out_status/err_row/err_col (result out),
//           single_cnt/uncorr_cnt (statistics).
// Modports: master = word source / result sink, slave = decoder.
interface product_code_decoder_if #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int CNT_W = 16
);
  localparam int NB = ROWS * COLS;
  localparam int N  = NB + ROWS + COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_word;
  logic             correct_en;
  logic             out_valid;
  logic             out_ready;
  logic [NB-1:0]    out_data;
  logic [1:0]       out_status;
  logic [RW-1:0]    err_row;
  logic [CW-1:0]    err_col;
  logic [CNT_W-1:0] single_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  modport master (
    output in_valid, in_word, correct_en, out_ready,
    input  in_ready, out_valid, out_data, out_status, err_row, err_col,
           single_cnt, uncorr_cnt
  );

  modport slave (
    input  in_valid, in_word, correct_en, out_ready,
    output in_ready, out_valid, out_data, out_status, err_row, err_col,
           single_cnt, uncorr_cnt
  );

endinterface

// File: rtl/product_code_decoder_pc_onehot_locate.sv
// rtl/product_code_decoder_pc_onehot_locate.sv - popcount and lowest-set-bit index of a vector
//
// Purpose: reduces a syndrome vector to its weight and the position of its lowest set bit.
// Ports  : i_vec (W bits in), o_pop (PW-bit population count), o_idx (IW-bit lowest set index,
//          0 when i_vec is all zeros).
module pc_onehot_locate #(
  parameter int W  = 8,
  parameter int PW = $clog2(W) + 1,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [PW-1:0] o_pop,
  output logic [IW-1:0] o_idx
);

  // Walk from the top down so the last hit recorded is the lowest set bit.
  always_comb begin
    o_pop = '0;
    o_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_pop = o_pop + PW'(1);
        o_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/product_code_decoder.sv
// rtl/product_code_decoder.sv - row-serial 2-D parity product-code decoder with error statistics
//
// Purpose: accepts one ROWS x COLS product-code word, scans one row per cycle, classifies the
//          syndrome, optionally corrects a single data-bit error and holds the result until taken.
// Ports  : clk, rst_n (async active-low), bus (product_code_decoder_if.slave: word in,
//          result out, saturating single_cnt/uncorr_cnt).
module product_code_decoder
  import product_code_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_code_decoder_if.slave bus
);

  localparam int NB      = ROWS * COLS;
  localparam int N       = NB + ROWS + COLS;
  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);
  localparam int MAXRC   = (ROWS > COLS) ? ROWS : COLS;
  localparam int PCW     = $clog2(MAXRC) + 1;
  localparam int CP_BASE = colpar_idx(0, ROWS, COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [N-1:0]     r_word;
  logic             r_cen;
  logic [RW-1:0]    r_row;
  logic [ROWS-1:0]  r_row_err;
  logic [COLS-1:0]  r_col_acc;
  logic [NB-1:0]    r_data;
  status_e          r_status;
  logic [RW-1:0]    r_err_row;
  logic [CW-1:0]    r_err_col;
  logic [CNT_W-1:0] r_single_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  logic             w_in_ready;
  logic             w_out_valid;
  logic [COLS-1:0]  w_row_data;
  logic             w_row_par;
  logic [COLS-1:0]  w_col_err;
  logic [PCW-1:0]   w_row_pop;
  logic [PCW-1:0]   w_col_pop;
  logic [RW-1:0]    w_row_idx;
  logic [CW-1:0]    w_col_idx;
  status_e          w_status;
  logic [NB-1:0]    w_flip_mask;

  assign w_row_data = r_word[int'(r_row) * COLS +: COLS];
  assign w_row_par  = r_word[rowpar_idx(int'(r_row), ROWS, COLS)];
  assign w_col_err  = r_col_acc ^ r_word[CP_BASE +: COLS];

  pc_onehot_locate #(.W(ROWS), .PW(PCW), .IW(RW)) u_row_loc (
    .i_vec (r_row_err),
    .o_pop (w_row_pop),
    .o_idx (w_row_idx)
  );

  pc_onehot_locate #(.W(COLS), .PW(PCW), .IW(CW)) u_col_loc (
    .i_vec (w_col_err),
    .o_pop (w_col_pop),
    .o_idx (w_col_idx)
  );

  always_comb begin
    w_status = UNCORRECTABLE;
    if (w_row_pop == PCW'(0) && w_col_pop == PCW'(0))
      w_status = CLEAN;
    else if (w_row_pop == PCW'(1) && w_col_pop == PCW'(1))
      w_status = SINGLE_DATA;
    else if ((w_row_pop == PCW'(1) && w_col_pop == PCW'(0)) ||
             (w_row_pop == PCW'(0) && w_col_pop == PCW'(1)))
      w_status = CHECK_BIT;
  end

  // Only a located single data error with correction enabled touches the payload.
  assign w_flip_mask = (w_status == SINGLE_DATA && r_cen)
                     ? (NB'(1) << data_idx(int'(w_row_idx), int'(w_col_idx), COLS))
                     : '0;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)        w_next_state = SCAN;
      SCAN:    if (r_row == LAST_ROW)   w_next_state = LOCATE;
      LOCATE:                           w_next_state = HOLD;
      HOLD:    if (bus.out_ready)       w_next_state = IDLE;
      default:                          w_next_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_in_ready  = (r_state == IDLE);
    w_out_valid = (r_state == HOLD);
  end

  // Datapath: capture, row scan, classification and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word       <= '0;
      r_cen        <= 1'b0;
      r_row        <= '0;
      r_row_err    <= '0;
      r_col_acc    <= '0;
      r_data       <= '0;
      r_status     <= CLEAN;
      r_err_row    <= '0;
      r_err_col    <= '0;
      r_single_cnt <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_word    <= bus.in_word;
            r_cen     <= bus.correct_en;
            r_row     <= '0;
            r_row_err <= '0;
            r_col_acc <= '0;
          end
        end
        SCAN: begin
          r_row_err[r_row] <= (^w_row_data) ^ w_row_par;
          r_col_acc        <= r_col_acc ^ w_row_data;
          if (r_row != LAST_ROW) r_row <= r_row + RW'(1);
        end
        LOCATE: begin
          r_data    <= r_word[NB-1:0] ^ w_flip_mask;
          r_status  <= w_status;
          r_err_row <= (w_status == SINGLE_DATA) ? w_row_idx : '0;
          r_err_col <= (w_status == SINGLE_DATA) ? w_col_idx : '0;
          if (w_status == SINGLE_DATA && r_single_cnt != '1)
            r_single_cnt <= r_single_cnt + CNT_W'(1);
          if (w_status == UNCORRECTABLE && r_uncorr_cnt != '1)
            r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = r_data;
  assign bus.out_status = r_status;
  assign bus.err_row    = r_err_row;
  assign bus.err_col    = r_err_col;
  assign bus.single_cnt = r_single_cnt;
  assign bus.uncorr_cnt = r_uncorr_cnt;

endmodule

// File: tb/tb_product_code_decoder.sv
// tb/tb_product_code_decoder.sv - scoreboard bench for product_code_decoder
module tb_product_code_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  product_code_decoder_if #(.ROWS(8), .COLS(8), .CNT_W(16)) bus ();
  product_code_decoder_if #(.ROWS(8), .COLS(8), .CNT_W(2))  bus2 ();

  product_code_decoder #(.ROWS(8), .COLS(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  product_code_decoder #(.ROWS(8), .COLS(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  status;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [15:0] sc;
    logic [15:0] uc;
    int          hs;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [63:0] D = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] E = 64'hFFFF_0000_A5A5_5A5A;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [79:0] enc(input logic [63:0] d);
    logic [79:0] w;
    logic        p;
    w = '0;
    w[63:0] = d;
    for (int r = 0; r < 8; r++) w[64 + r] = ^d[r*8 +: 8];
    for (int c = 0; c < 8; c++) begin
      p = 1'b0;
      for (int r = 0; r < 8; r++) p = p ^ d[r*8 + c];
      w[72 + c] = p;
    end
    return w;
  endfunction

  function automatic logic [79:0] bit80(input int i);
    logic [79:0] one;
    one = 80'd1;
    return one << i;
  endfunction

  function automatic logic [63:0] bit64(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  function automatic exp_t mk(input logic [63:0] data, input logic [1:0] st,
                              input logic [2:0] row, input logic [2:0] col,
                              input logic [15:0] sc, input logic [15:0] uc);
    exp_t e;
    e.data = data; e.status = st; e.row = row; e.col = col;
    e.sc = sc; e.uc = uc; e.hs = 0;
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [79:0] w, input logic cen, input exp_t e);
    int n;
    n = 0;
    bus.in_word    = w;
    bus.correct_en = cen;
    bus.in_valid   = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      e.hs = cyc;
      bus.in_valid = 1'b0;
      bus.correct_en = ~cen;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.in_ready && exp_q.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(bus.in_ready), 64'd1);
  endtask

  // Monitor: pops one expected entry per result presented.
  logic in_hold = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_hold = 1'b0;
    end else if (bus.out_valid) begin
      if (!in_hold) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(bus.out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", 64'(cyc + 1 - e.hs), 64'd10);
          chk("out_data", bus.out_data, e.data);
          chk("out_status", 64'(bus.out_status), 64'(e.status));
          chk("err_row", 64'(bus.err_row), 64'(e.row));
          chk("err_col", 64'(bus.err_col), 64'(e.col));
          chk("single_cnt", 64'(bus.single_cnt), 64'(e.sc));
          chk("uncorr_cnt", 64'(bus.uncorr_cnt), 64'(e.uc));
        end
        in_hold = 1'b1;
      end
      if (bus.out_ready) in_hold = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.in_word = '0; bus.correct_en = 1'b0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_word = '0; bus2.correct_en = 1'b1; bus2.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_status", 64'(bus.out_status), 64'd0);
    chk("rst_err_pos", 64'({bus.err_row, bus.err_col}), 64'd0);
    chk("rst_counters", 64'({bus.single_cnt, bus.uncorr_cnt}), 64'd0);

    send(enc(D), 1'b1, mk(D, 2'd0, 3'd0, 3'd0, 16'd0, 16'd0));
    wait_idle();
    send(enc(D) ^ bit80(19), 1'b1, mk(D, 2'd1, 3'd2, 3'd3, 16'd1, 16'd0));
    wait_idle();
    send(enc(D) ^ bit80(19), 1'b0, mk(D ^ bit64(19), 2'd1, 3'd2, 3'd3, 16'd2, 16'd0));
    wait_idle();
    send(enc(D) ^ bit80(69), 1'b1, mk(D, 2'd2, 3'd0, 3'd0, 16'd2, 16'd0));
    wait_idle();
    send(enc(D) ^ bit80(0) ^ bit80(9), 1'b1,
         mk(D ^ bit64(0) ^ bit64(9), 2'd3, 3'd0, 3'd0, 16'd2, 16'd1));
    wait_idle();
    send(enc(D) ^ bit80(0) ^ bit80(1), 1'b1,
         mk(D ^ bit64(0) ^ bit64(1), 2'd3, 3'd0, 3'd0, 16'd2, 16'd2));
    wait_idle();

    // Backpressure with a second word waiting
    bus.out_ready = 1'b0;
    send(enc(E), 1'b1, mk(E, 2'd0, 3'd0, 3'd0, 16'd2, 16'd2));
    bus.in_word    = enc(64'd0) ^ bit80(63);
    bus.correct_en = 1'b1;
    bus.in_valid   = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid_hold", 64'(bus.out_valid), 64'd1);
      chk("bp_out_data", bus.out_data, E);
      chk("bp_counters", 64'({bus.single_cnt, bus.uncorr_cnt}), {32'd0, 16'd2, 16'd2});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    send(enc(64'd0) ^ bit80(63), 1'b1, mk(64'd0, 2'd1, 3'd7, 3'd7, 16'd3, 16'd2));
    wait_idle();

    // Reset in the middle of the row scan
    send(enc(D), 1'b1, mk(D, 2'd0, 3'd0, 3'd0, 16'd3, 16'd2));
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_counters", 64'({bus.single_cnt, bus.uncorr_cnt}), 64'd0);
    send(enc(D), 1'b1, mk(D, 2'd0, 3'd0, 3'd0, 16'd0, 16'd0));
    wait_idle();

    // Saturation on the 2-bit counter instance
    for (int k = 0; k < 4; k++) begin
      bus2.in_word  = enc(D) ^ bit80(0) ^ bit80(9);
      bus2.in_valid = 1'b1;
      n = 0;
      while (!bus2.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      @(negedge clk);
      bus2.in_valid = 1'b0;
      n = 0;
      while (!bus2.out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("sat_out_valid", 64'(bus2.out_valid), 64'd1);
      chk("sat_status", 64'(bus2.out_status), 64'd3);
      @(negedge clk);
    end
    chk("sat_uncorr_cnt", 64'(bus2.uncorr_cnt), 64'd3);
    chk("sat_single_cnt", 64'(bus2.single_cnt), 64'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
